clk_div_multi: RTL

//  Parametrised, multi-channel successor to the single fixed-ratio divider.
//  NUM_CH independent channels, each with a run-time programmable half-period, enable and glitch-free ratio update.
//  Per channel: a 50%-duty divided level (sclk) and a one-cycle rising-edge strobe (tick).

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_multi_if.sv | 30 +++
 rtl/clk_div_chan.sv | 112 +++++++++++
 rtl/clk_div_multi.sv | 63 ++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults, types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_W_DEF    = 16;
  localparam int CLK_DIV_RST_HALF_DEF = 50;
  localparam int CLK_DIV_MAX_CH       = 16;

  typedef logic [CLK_DIV_CNT_W_DEF-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PARK  = 2'd2
  } chan_state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration port of clk_div_multi plus per-channel park-FSM state for observation.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CLK_DIV_CNT_W_DEF
);

  localparam int CH_W = ch_sel_w(NUM_CH);

  // Handshake: a request transfers on a rising clk edge where cfg_valid and cfg_ready are
  // both high; cfg_ready depends only on the addressed channel, so cfg_ch must be stable
  // while cfg_valid is high, and the master holds its payload until the transfer happens.
  logic                   cfg_valid;
  logic [CH_W-1:0]        cfg_ch;
  logic [CNT_W-1:0]       cfg_half;
  logic                   cfg_ready;
  logic [NUM_CH-1:0][1:0] dbg_state;

  modport master (
    output cfg_valid, cfg_ch, cfg_half,
    input  cfg_ready, dbg_state
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half,
    output cfg_ready, dbg_state
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, shadowed ratio update and run/drain/park control.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CLK_DIV_CNT_W_DEF,
  parameter int RST_HALF = CLK_DIV_RST_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             pending,
  output logic             sclk,
  output logic             tick,
  output chan_state_e      state
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_HALF_V = CNT_W'(RST_HALF);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] half, half_n;
  logic [CNT_W-1:0] shadow, shadow_n;
  logic             pending_n, sclk_n, tick_n;
  logic             boundary;
  chan_state_e      state_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      half    <= RST_HALF_V;
      shadow  <= RST_HALF_V;
      pending <= 1'b0;
      sclk    <= 1'b0;
      tick    <= 1'b0;
      state   <= ST_RUN;
    end else begin
      cnt     <= cnt_n;
      half    <= half_n;
      shadow  <= shadow_n;
      pending <= pending_n;
      sclk    <= sclk_n;
      tick    <= tick_n;
      state   <= state_n;
    end
  end

  // ">=" rather than "==" so a shrunk ratio below the current count ends the phase at once.
  assign boundary = (half != '0) && (cnt >= half - ONE);

  always_comb begin
    cnt_n     = cnt;
    half_n    = half;
    shadow_n  = shadow;
    pending_n = pending;
    sclk_n    = sclk;
    tick_n    = 1'b0;
    state_n   = state;

    if (sync) begin
      cnt_n   = '0;
      sclk_n  = 1'b0;
      state_n = en ? ST_RUN : ST_PARK;
      if (cfg_sel) begin
        shadow_n  = cfg_half;
        half_n    = cfg_half;
        pending_n = 1'b0;
      end else if (pending) begin
        half_n    = shadow;
        pending_n = 1'b0;
      end
    end else begin
      if (cfg_sel) begin
        shadow_n  = cfg_half;
        pending_n = 1'b1;
      end

      if ((half == '0) || (state == ST_PARK)) begin
        // Stopped or parked: output is already low, so a new ratio can be taken right away.
        cnt_n   = '0;
        sclk_n  = 1'b0;
        state_n = en ? ST_RUN : ST_PARK;
        if (pending) begin
          half_n    = shadow;
          pending_n = 1'b0;
        end
      end else if (!en && !sclk) begin
        cnt_n   = '0;
        state_n = ST_PARK;
      end else if (boundary) begin
        cnt_n  = '0;
        sclk_n = !sclk;
        tick_n = !sclk;
        if (pending) begin
          half_n    = shadow;
          pending_n = 1'b0;
          if (shadow == '0) begin
            sclk_n = 1'b0;
            tick_n = 1'b0;
          end
        end
        state_n = en ? ST_RUN : ST_PARK;
      end else begin
        cnt_n   = cnt + ONE;
        state_n = en ? ST_RUN : ST_DRAIN;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable dividers producing 50% levels and rising-edge strobes.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CLK_DIV_CNT_W_DEF,
  parameter int RST_HALF = CLK_DIV_RST_HALF_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  clk_div_multi_if.slave    cfg,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] tick
);

  localparam int CH_W  = ch_sel_w(NUM_CH);
  localparam int PAD_N = 1 << CH_W;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] sel;
  logic [PAD_N-1:0]  pending_pad;
  logic              accept;
  chan_state_e       chan_state [NUM_CH];

  // Unused select codes read as never-pending, so requests to them are accepted and dropped.
  always_comb begin
    pending_pad             = '0;
    pending_pad[NUM_CH-1:0] = pending;
  end

  assign cfg.cfg_ready = !pending_pad[cfg.cfg_ch];
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = accept && (cfg.cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .RST_HALF (RST_HALF)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .sync     (sync),
      .cfg_sel  (sel[g]),
      .cfg_half (cfg.cfg_half),
      .pending  (pending[g]),
      .sclk     (sclk[g]),
      .tick     (tick[g]),
      .state    (chan_state[g])
    );

    assign cfg.dbg_state[g] = chan_state[g];
  end

endmodule
